// File: rtl/regfile_pkg.sv
// Shared types and helpers for the integer register file and its scoreboard.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  localparam int RF_XLEN_DEF  = 64;
  localparam int RF_NREGS_DEF = 32;

  // True when addr names an implemented register (matters when nregs is not a power of two).
  function automatic logic addr_valid(input logic [31:0] addr, input logic [31:0] nregs);
    if (addr < nregs) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy flop per register, set by reserve,
// cleared by write (set wins on a same-register collision), with NRD
// combinational lookup ports. Addresses with no matching entry read as idle.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = RF_NREGS_DEF,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_srst,
  input  logic              i_set_en,
  input  logic [AW-1:0]     i_set_addr,
  input  logic              i_clr_en,
  input  logic [AW-1:0]     i_clr_addr,
  input  logic [NRD*AW-1:0] i_lk_addr,
  output logic [NRD-1:0]    o_lk_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  // Next busy vector: a reserve beats a retiring write to the same register.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < NREGS; i++) begin
      if (i_set_en && (i_set_addr == AW'(i))) begin
        w_busy_nxt[i] = 1'b1;
      end else if (i_clr_en && (i_clr_addr == AW'(i))) begin
        w_busy_nxt[i] = 1'b0;
      end else begin
        w_busy_nxt[i] = r_busy[i];
      end
    end
  end

  // Busy flops: async reset, soft clear while the storage sweep runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= {NREGS{1'b0}};
    end else if (i_srst) begin
      r_busy <= {NREGS{1'b0}};
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Lookup ports: out-of-range addresses match no entry and read idle.
  always_comb begin
    o_lk_busy = {NRD{1'b0}};
    for (int k = 0; k < NRD; k++) begin
      for (int i = 0; i < NREGS; i++) begin
        if (i_lk_addr[k*AW +: AW] == AW'(i)) begin
          o_lk_busy[k] = r_busy[i];
        end else begin
          o_lk_busy[k] = o_lk_busy[k];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with hardwired x0, same-cycle
// write bypass, pending-write scoreboard and a post-reset clear sweep
// that replaces a wide reset on the storage array.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN     = RF_XLEN_DEF,
  parameter  int NREGS    = RF_NREGS_DEF,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                resv_en,
  input  logic [AW-1:0]       resv_addr,
  output logic                ready
);

  rf_state_t         r_state;
  logic [AW-1:0]     r_clr_ptr;
  logic              r_ready;
  logic [XLEN-1:0]   r_mem [NREGS];

  logic              w_run;
  logic              w_wr_ok;
  logic              w_resv_ok;
  logic              w_mem_we;
  logic [AW-1:0]     w_mem_waddr;
  logic [XLEN-1:0]   w_mem_wdata;
  logic [NRD-1:0]    w_sb_busy;

  assign w_run = (r_state == RF_READY);

  // Qualify write/reserve: only in READY, in range, and never for hardwired x0.
  always_comb begin
    w_wr_ok   = w_run && wr_en && addr_valid(32'(wr_addr), 32'(NREGS))
                && !((ZERO_REG != 0) && (wr_addr == {AW{1'b0}}));
    w_resv_ok = w_run && resv_en && addr_valid(32'(resv_addr), 32'(NREGS))
                && !((ZERO_REG != 0) && (resv_addr == {AW{1'b0}}));
  end

  // Clear FSM: zero one entry per cycle, enter READY after the last entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RF_CLEAR;
      r_clr_ptr <= {AW{1'b0}};
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        RF_CLEAR: begin
          if (r_clr_ptr == AW'(NREGS - 1)) begin
            r_state <= RF_READY;
            r_ready <= 1'b1;
          end else begin
            r_clr_ptr <= r_clr_ptr + {{(AW-1){1'b0}}, 1'b1};
          end
        end
        RF_READY: begin
          r_state <= RF_READY;
          r_ready <= 1'b1;
        end
        default: begin
          r_state   <= RF_CLEAR;
          r_clr_ptr <= {AW{1'b0}};
          r_ready   <= 1'b0;
        end
      endcase
    end
  end

  // Storage write source: sweep zeroes during CLEAR, qualified writes afterwards.
  always_comb begin
    if (r_state == RF_CLEAR) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = r_clr_ptr;
      w_mem_wdata = {XLEN{1'b0}};
    end else begin
      w_mem_we    = w_wr_ok;
      w_mem_waddr = wr_addr;
      w_mem_wdata = wr_data;
    end
  end

  // Storage array: deliberately unreset, the sweep initialises it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (w_mem_we && (w_mem_waddr == AW'(i))) begin
        r_mem[i] <= w_mem_wdata;
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_srst     (r_state == RF_CLEAR),
    .i_set_en   (w_resv_ok),
    .i_set_addr (resv_addr),
    .i_clr_en   (w_wr_ok),
    .i_clr_addr (wr_addr),
    .i_lk_addr  (rd_addr),
    .o_lk_busy  (w_sb_busy)
  );

  // Read ports: x0/out-of-range read idle zero, bypass beats array and busy.
  always_comb begin
    logic [AW-1:0]   v_a;
    logic [XLEN-1:0] v_mem;
    logic            v_byp;
    rd_data = {(NRD*XLEN){1'b0}};
    rd_busy = {NRD{1'b0}};
    for (int k = 0; k < NRD; k++) begin
      v_a   = rd_addr[k*AW +: AW];
      v_mem = {XLEN{1'b0}};
      for (int i = 0; i < NREGS; i++) begin
        if (v_a == AW'(i)) begin
          v_mem = r_mem[i];
        end else begin
          v_mem = v_mem;
        end
      end
      v_byp = (BYPASS != 0) && w_wr_ok && (wr_addr == v_a);
      if (!w_run || !addr_valid(32'(v_a), 32'(NREGS))
          || ((ZERO_REG != 0) && (v_a == {AW{1'b0}}))) begin
        rd_data[k*XLEN +: XLEN] = {XLEN{1'b0}};
        rd_busy[k]              = 1'b0;
      end else if (v_byp) begin
        rd_data[k*XLEN +: XLEN] = wr_data;
        rd_busy[k]              = 1'b0;
      end else begin
        rd_data[k*XLEN +: XLEN] = v_mem;
        rd_busy[k]              = w_sb_busy[k];
      end
    end
  end

  assign ready = r_ready;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: instance A (32 regs, bypass) and instance B
// (24 regs, no bypass) share stimulus and are compared every cycle
// against an array-based reference model of the register file rules.
module tb_regfile_mp;

  logic         clk;
  logic         rst_n;
  logic [9:0]   rd_addr;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [63:0]  wr_data;
  logic         resv_en;
  logic [4:0]   resv_addr;
  logic [127:0] rd_data_a, rd_data_b;
  logic [1:0]   rd_busy_a, rd_busy_b;
  logic         ready_a, ready_b;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model
  logic [63:0] m_mem  [2][32];
  bit          m_busy [2][32];
  int          m_edges;
  int          cfg_n   [2] = '{32, 24};
  bit          cfg_byp [2] = '{1'b1, 1'b0};

  regfile_mp #(.XLEN(64), .NREGS(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .resv_en(resv_en),
    .resv_addr(resv_addr), .ready(ready_a)
  );

  regfile_mp #(.XLEN(64), .NREGS(24), .NRD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .resv_en(resv_en),
    .resv_addr(resv_addr), .ready(ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_edges = 0;
    for (int j = 0; j < 2; j++) begin
      for (int r = 0; r < 32; r++) begin
        m_mem[j][r]  = 64'd0;
        m_busy[j][r] = 1'b0;
      end
    end
  endtask

  task automatic model_update();
    if (rst_n) begin
      for (int j = 0; j < 2; j++) begin
        if (m_edges >= cfg_n[j]) begin
          if (wr_en && (int'(wr_addr) < cfg_n[j]) && (wr_addr != 5'd0)) begin
            m_mem[j][wr_addr]  = wr_data;
            m_busy[j][wr_addr] = 1'b0;
          end
          if (resv_en && (int'(resv_addr) < cfg_n[j]) && (resv_addr != 5'd0)) begin
            m_busy[j][resv_addr] = 1'b1;
          end
        end
      end
      m_edges++;
    end
  endtask

  task automatic check_outputs();
    logic [127:0] d;
    logic [1:0]   b;
    logic         r, er, eb;
    logic [4:0]   a;
    logic [63:0]  ed;
    for (int j = 0; j < 2; j++) begin
      d  = (j == 0) ? rd_data_a : rd_data_b;
      b  = (j == 0) ? rd_busy_a : rd_busy_b;
      r  = (j == 0) ? ready_a : ready_b;
      er = rst_n && (m_edges >= cfg_n[j]);
      check_eq($sformatf("ready%0d", j), {63'd0, r}, {63'd0, er});
      for (int k = 0; k < 2; k++) begin
        a = rd_addr[k*5 +: 5];
        if (!er || (int'(a) >= cfg_n[j]) || (a == 5'd0)) begin
          ed = 64'd0; eb = 1'b0;
        end else if (cfg_byp[j] && wr_en && (wr_addr == a)) begin
          ed = wr_data; eb = 1'b0;
        end else begin
          ed = m_mem[j][a]; eb = m_busy[j][a];
        end
        check_eq($sformatf("data%0d_p%0d_a%0d", j, k, a), d[k*64 +: 64], ed);
        check_eq($sformatf("busy%0d_p%0d_a%0d", j, k, a), {63'd0, b[k]}, {63'd0, eb});
      end
    end
  endtask

  task automatic set_inputs(input bit we, input logic [4:0] wa, input logic [63:0] wd,
                            input bit re, input logic [4:0] ra, input logic [9:0] rda);
    wr_en = we; wr_addr = wa; wr_data = wd;
    resv_en = re; resv_addr = ra; rd_addr = rda;
  endtask

  task automatic finish_cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input bit we, input logic [4:0] wa, input logic [63:0] wd,
                       input bit re, input logic [4:0] ra, input logic [9:0] rda);
    set_inputs(we, wa, wd, re, ra, rda);
    finish_cycle();
  endtask

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    else return 5'($urandom_range(0, 7));
  endfunction

  task automatic drive_random();
    drive(1'($urandom_range(0, 1)), pick(), {$urandom, $urandom},
          ($urandom_range(0, 9) < 4), pick(), {pick(), pick()});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #2;
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_inputs(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 10'd0);
    model_reset();
    do_reset();

    // clear sweep with writes/reserves issued during CLEAR
    for (int i = 0; i < 32; i++) begin
      if (i < 20) drive(1'b1, pick(), {$urandom, $urandom}, 1'b1, pick(), {pick(), pick()});
      else drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, {pick(), pick()});
    end
    for (int r = 0; r < 32; r += 2) begin
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, {5'(r + 1), 5'(r)});
    end

    // write then read back on two ports
    drive(1'b1, 5'd1, 64'h1234567890ABCDEF, 1'b0, 5'd0, 10'd0);
    drive(1'b1, 5'd2, 64'hFEDCBA0987654321, 1'b0, 5'd0, 10'd0);
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, {5'd1, 5'd2});
    check_eq("wr_rd_p0", rd_data_a[63:0],   64'hFEDCBA0987654321);
    check_eq("wr_rd_p1", rd_data_a[127:64], 64'h1234567890ABCDEF);

    // bypass on A, no bypass on B
    set_inputs(1'b1, 5'd5, 64'hA5, 1'b0, 5'd0, {5'd0, 5'd5});
    #2;
    check_eq("byp_data",  rd_data_a[63:0], 64'hA5);
    check_eq("byp_busy",  {63'd0, rd_busy_a[0]}, 64'd0);
    check_eq("nobyp_old", rd_data_b[63:0], 64'd0);
    finish_cycle();
    set_inputs(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, {5'd0, 5'd5});
    #1;
    check_eq("nobyp_new", rd_data_b[63:0], 64'hA5);

    // x0 is hardwired
    drive(1'b1, 5'd0, 64'hFF, 1'b1, 5'd0, 10'd0);
    set_inputs(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 10'd0);
    #1;
    check_eq("x0_data", rd_data_a[127:64] | rd_data_a[63:0], 64'd0);
    check_eq("x0_busy", {62'd0, rd_busy_a}, 64'd0);

    // scoreboard: reserve, write+reserve, write
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, {5'd7, 5'd7});
    set_inputs(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, {5'd7, 5'd7});
    #1;
    check_eq("sb_set", {62'd0, rd_busy_a}, 64'd3);
    drive(1'b1, 5'd7, 64'h77, 1'b1, 5'd7, {5'd7, 5'd7});
    set_inputs(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, {5'd7, 5'd7});
    #1;
    check_eq("sb_setwins", {62'd0, rd_busy_a}, 64'd3);
    check_eq("sb_setwins_data", rd_data_a[63:0], 64'h77);
    drive(1'b1, 5'd7, 64'h78, 1'b0, 5'd0, {5'd7, 5'd7});
    set_inputs(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, {5'd7, 5'd7});
    #1;
    check_eq("sb_clr", {62'd0, rd_busy_a}, 64'd0);
    check_eq("sb_clr_data", rd_data_a[127:64], 64'h78);

    // randomized traffic
    for (int i = 0; i < 600; i++) drive_random();

    // reset in the middle of the sweep
    do_reset();
    for (int i = 0; i < 10; i++) drive_random();
    do_reset();
    for (int i = 0; i < 40; i++) drive_random();
    for (int i = 0; i < 200; i++) drive_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
